// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, one-deep read pipeline and 2-entry prefetch buffer with redirect/halt.
// Optional IFETCH_PERF_EN adds a saturating stallCount output.
module instruction_fetch #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [15:0]     addressBus,
  output logic            readFromInst,
  input  logic [31:0]     instructionData,
  input  logic            branchTaken,
  input  logic [PC_W-1:0] branchTarget,
  input  logic            halt,
  output logic [31:0]     instOut,
  output logic [PC_W-1:0] pcOut,
  output logic            instValid,
  input  logic            instReady
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]     stallCount
`endif
);
  logic [PC_W-1:0] pc_q, pc_d, ipc_q, ipc_d, p0_q, p0_d, p1_q, p1_d;
  logic [31:0] i0_q, i0_d, i1_q, i1_d;
  logic [1:0] count_q, count_d, cp;
  logic inflight_q, inflight_d, pop, push, issue;
  logic [2:0] credit;
  assign instValid = count_q != 2'd0;
  assign pop = instValid & instReady;
  assign credit = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = reset & ~halt & ~branchTaken & (credit < 3'd2);
  assign push = inflight_q & ~branchTaken;
  assign cp = count_q - {1'b0, pop};
  assign readFromInst = issue;
  assign addressBus = 16'({pc_q, 8'h00});
  assign instOut = i0_q;
  assign pcOut = p0_q;
  // Pop shifts the second entry forward; a push lands at the first slot free after the pop.
  always_comb begin
    pc_d = branchTaken ? branchTarget : issue ? pc_q + PC_W'(1) : pc_q;
    inflight_d = issue;
    ipc_d = issue ? pc_q : ipc_q;
    p0_d = pop ? p1_q : p0_q;
    i0_d = pop ? i1_q : i0_q;
    p1_d = p1_q;
    i1_d = i1_q;
    if (push && cp == 2'd0) begin
      p0_d = ipc_q;
      i0_d = instructionData;
    end
    if (push && cp != 2'd0) begin
      p1_d = ipc_q;
      i1_d = instructionData;
    end
    count_d = branchTaken ? 2'd0 : cp + {1'b0, push};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ipc_q <= '0;
      inflight_q <= 1'b0;
      count_q <= 2'd0;
      p0_q <= '0;
      p1_q <= '0;
      i0_q <= '0;
      i1_q <= '0;
    end else begin
      pc_q <= pc_d;
      ipc_q <= ipc_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      p0_q <= p0_d;
      p1_q <= p1_d;
      i0_q <= i0_d;
      i1_q <= i1_d;
    end
  end
`ifdef IFETCH_PERF_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (~halt & ~issue & (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= 16'd0;
    else stall_q <= stall_d;
  end
  assign stallCount = stall_q;
`endif
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the instruction memory (`instruction`) and downstream decode. Holds the program counter and drives the memory's `addressBus`/`readFromInst`. Captures `instructionData` one cycle after each read into a 2-entry prefetch buffer, then presents instructions to decode over a valid/ready handshake. Supports branch redirect with flush, and halt.

## Interface
- `PC_W`, 8: program-counter width (word index into instruction memory).
- `RESET_PC`, 0: PC value loaded on reset.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addressBus` out 16: memory address, always `{pc, 8'h00}`. Word index is carried in `[15:8]`; `[7:0]` is always 0.
- `readFromInst` out 1: read strobe to instruction memory.
- `instructionData` in 32: memory read data, valid the cycle after a sampled `readFromInst`.
- `branchTaken` in 1: redirect request, one cycle.
- `branchTarget` in PC_W: redirect target.
- `halt` in 1: level; suppresses new reads.
- `instOut` out 32: buffer head instruction.
- `pcOut` out PC_W: PC of `instOut`.
- `instValid` out 1: buffer non-empty.
- `instReady` in 1: decode accepts head.

## Operation
- State:
  - `pc`;
  - `inflight` flag plus `inflightPc`;
  - 2-entry FIFO of {pc, instr} with `count` 0..2.
- `pop` = `instValid & instReady`.
- Issue condition: `issue = reset & ~halt & ~branchTaken & (count + inflight - pop < 2)`.
- `readFromInst = issue`, combinational. It is 0 while `reset` is low.
- On an edge with `issue`:
  - `inflight <= 1`, `inflightPc <= pc`;
  - `pc <= pc + 1`, wrapping from 2^PC_W-1 to 0;
  - otherwise, if no issue, `inflight <= 0`.
- On an edge with `inflight` = 1 and no `branchTaken`: push {`inflightPc`, `instructionData`} into the FIFO.
- Push and pop on the same edge are both performed; `count` is unchanged.
- Credit rule guarantees no push into a full FIFO. Overflow is impossible by construction.
- Redirect: on an edge with `branchTaken`:
  - `pc <= branchTarget`;
  - FIFO emptied (`count <= 0`);
  - `inflight <= 0`, so returning data is discarded;
  - no read issued that cycle.
  - A simultaneous pop counts as accepted by decode; the remainder is flushed.
- Halt: new reads stop. An in-flight read still completes and is pushed. The buffer drains normally. `pc` holds.
- `branchTaken` while halted still loads `pc` and flushes.

## Timing
- Reset values:
  - `pc = RESET_PC`, `count = 0`, `inflight = 0`;
  - `instValid = 0`, `readFromInst = 0`;
  - `instOut = 0`, `pcOut = 0`, `addressBus = {RESET_PC, 8'h00}`.
- Reset is effective immediately on assertion. It may occur mid-operation: in-flight data is dropped.
- Read latency: `readFromInst` sampled at edge E → data captured at edge E+1 → `instValid` high after E+1.
- First `instValid` appears 2 edges after reset release.
- With `instReady` held high: one instruction per cycle sustained; `readFromInst` stays high.
- With `instReady` low: at most 2 buffered instructions plus 0 in flight. `readFromInst` deasserts once `count + inflight = 2`.
- Redirect penalty: the first target instruction is valid 2 edges after the `branchTaken` edge.
- `instOut`/`pcOut` hold stable while `instValid & ~instReady`.

## Configuration
- `IFETCH_PERF_EN`:
  - When defined, adds output `stallCount` (16 bits), reset 0.
  - It increments on every edge where `reset` is high, `halt` is low and `issue` is 0.
  - It saturates at 16'hFFFF.
- Without the macro, the port and counter do not exist. Fetch behaviour is identical either way.

## Test plan
- Reset release, `instReady` = 1, memory holding word k = k+100:
  - `addressBus` = 16'h0000, 16'h0100, 16'h0200…;
  - `instOut` = 100, 101, 102 with `pcOut` = 0, 1, 2, valid every cycle from edge 2.
- `instReady` held low for 5 cycles:
  - `readFromInst` drops after 2 reads;
  - `instOut` = 100 stable;
  - on release, 100, 101, 102 delivered in order with no loss or duplicate.
- `branchTaken` with `branchTarget` = 5 while 2 entries are buffered:
  - `instValid` = 0 next cycle;
  - `addressBus` = 16'h0500;
  - `instOut` = 105, `pcOut` = 5 two edges later.
- `branchTaken` and pop on the same edge:
  - the head counts as accepted;
  - no stale instruction appears;
  - the next valid instruction is the target.
- PC wrap: `RESET_PC` = 255, PC_W = 8 → `addressBus` 16'hFF00 then 16'h0000; `pcOut` 255 then 0.
- `halt` high for 4 cycles, then assert `reset` low mid-stream:
  - during halt, `readFromInst` = 0 and the buffer drains;
  - on reset, all outputs immediately return to their reset values;
  - with `IFETCH_PERF_EN`, `stallCount` is unchanged during halt and reads 0 after reset.
